// File: rtl/histo_capture_sequencer.sv
// histo_capture_sequencer: round-robin arbitrated capture of sorted histogram results
// with done-toggle synchronisation, timeout and holdoff between captures.
module histo_capture_sequencer #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH_SIZE = 6,
  parameter int TIMEOUT_CYC = 4096,
  parameter int HOLDOFF_CYC = 32
) (
  input  logic                   clk200,
  input  logic                   rstn,
  input  logic                   En,
  input  logic [1:0]             Req,
  input  logic                   SortDoneTgl,
  input  logic [DATA_SIZE-1:0]   MaxCountData1,
  input  logic [DATA_SIZE-1:0]   MaxCountData2,
  input  logic [DATA_SIZE-1:0]   MaxCountData3,
  input  logic [LENGTH_SIZE-1:0] MaxCount1,
  input  logic [LENGTH_SIZE-1:0] MaxCount2,
  input  logic [LENGTH_SIZE-1:0] MaxCount3,
  output logic                   Collect,
  output logic                   Busy,
  output logic [1:0]             Grant,
  output logic [1:0]             Ack,
  output logic                   Err,
  output logic [DATA_SIZE-1:0]   ResData1,
  output logic [DATA_SIZE-1:0]   ResData2,
  output logic [DATA_SIZE-1:0]   ResData3,
  output logic [LENGTH_SIZE-1:0] ResCount1,
  output logic [LENGTH_SIZE-1:0] ResCount2,
  output logic [LENGTH_SIZE-1:0] ResCount3,
  output logic [15:0]            CaptureCount,
  output logic [7:0]             TimeoutCount
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WAIT, S_HOLD} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic r_hist, r_last, r_collect, r_err;
  logic [1:0] r_grant, r_ack, w_pick;
  logic [TW-1:0] r_tcnt;
  logic [HW-1:0] r_hcnt;
  logic w_done_edge, w_grant_now, w_success, w_timeout, w_hold_end;
  logic [DATA_SIZE-1:0] r_rd1, r_rd2, r_rd3;
  logic [LENGTH_SIZE-1:0] r_rc1, r_rc2, r_rc3;
  logic [15:0] r_capcnt;
  logic [7:0] r_tocnt;
  assign w_done_edge = r_sync[1] ^ r_hist;
  // r_last holds the index of the last granted requester; a tie goes to the other one
  assign w_pick = (Req == 2'b11) ? (r_last ? 2'b01 : 2'b10) : Req;
  always_comb begin
    w_next = r_state;
    w_grant_now = 1'b0;
    w_success = 1'b0;
    w_timeout = 1'b0;
    w_hold_end = 1'b0;
    case (r_state)
      S_IDLE: if (En && Req != 2'b00) begin
        w_grant_now = 1'b1;
        w_next = S_COLLECT;
      end
      S_COLLECT: w_next = S_WAIT;
      S_WAIT: if (w_done_edge) begin
        w_success = 1'b1;
        w_next = S_HOLD;
      end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
        w_timeout = 1'b1;
        w_next = S_HOLD;
      end
      S_HOLD: if (r_hcnt == HW'(HOLDOFF_CYC - 1)) begin
        w_hold_end = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk200 or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk200 or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_last <= 1'b1;
      r_collect <= 1'b0;
      r_err <= 1'b0;
      r_grant <= '0;
      r_ack <= '0;
      r_tcnt <= '0;
      r_hcnt <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_rd3 <= '0;
      r_rc1 <= '0;
      r_rc2 <= '0;
      r_rc3 <= '0;
      r_capcnt <= '0;
      r_tocnt <= '0;
    end else begin
      r_sync <= {r_sync[0], SortDoneTgl};
      r_hist <= r_sync[1];
      r_collect <= w_grant_now;
      r_ack <= (w_success || w_timeout) ? r_grant : 2'b00;
      r_err <= w_timeout;
      r_tcnt <= (r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
      r_hcnt <= (r_state == S_HOLD) ? r_hcnt + 1'b1 : '0;
      if (w_grant_now) begin
        r_grant <= w_pick;
        r_last <= w_pick[1];
      end else if (w_hold_end) r_grant <= '0;
      if (w_success) begin
        r_rd1 <= MaxCountData1;
        r_rd2 <= MaxCountData2;
        r_rd3 <= MaxCountData3;
        r_rc1 <= MaxCount1;
        r_rc2 <= MaxCount2;
        r_rc3 <= MaxCount3;
        r_capcnt <= r_capcnt + 1'b1;
      end
      if (w_timeout && r_tocnt != 8'hFF) r_tocnt <= r_tocnt + 1'b1;
    end
  end
  assign Collect = r_collect;
  assign Busy = (r_state != S_IDLE);
  assign Grant = r_grant;
  assign Ack = r_ack;
  assign Err = r_err;
  assign ResData1 = r_rd1;
  assign ResData2 = r_rd2;
  assign ResData3 = r_rd3;
  assign ResCount1 = r_rc1;
  assign ResCount2 = r_rc2;
  assign ResCount3 = r_rc3;
  assign CaptureCount = r_capcnt;
  assign TimeoutCount = r_tocnt;
endmodule

// File: tb/tb_histo_capture_sequencer.sv
// tb_histo_capture_sequencer: directed and randomized captures checked against a
// transaction-level model of arbitration, timing windows and result counters.
module tb_histo_capture_sequencer;
  localparam int DS = 4, LS = 6, T = 40, H = 5;
  logic clk200 = 1'b0, rstn = 1'b0, En = 1'b0, SortDoneTgl = 1'b0;
  logic [1:0] Req = 2'b00;
  logic [DS-1:0] md1 = '0, md2 = '0, md3 = '0;
  logic [LS-1:0] mc1 = '0, mc2 = '0, mc3 = '0;
  logic Collect, Busy, Err;
  logic [1:0] Grant, Ack;
  logic [DS-1:0] rd1, rd2, rd3;
  logic [LS-1:0] rc1, rc2, rc3;
  logic [15:0] cap_cnt;
  logic [7:0] to_cnt;
  int cyc = 0, checks = 0, errors = 0;
  int last_owner = 1, exp_cap = 0, exp_to = 0, last_collect = -1000;
  logic [3*DS-1:0] exp_d = '0;
  logic [3*LS-1:0] exp_c = '0;
  histo_capture_sequencer #(.DATA_SIZE(DS), .LENGTH_SIZE(LS), .TIMEOUT_CYC(T), .HOLDOFF_CYC(H)) dut (
    .clk200(clk200), .rstn(rstn), .En(En), .Req(Req), .SortDoneTgl(SortDoneTgl),
    .MaxCountData1(md1), .MaxCountData2(md2), .MaxCountData3(md3),
    .MaxCount1(mc1), .MaxCount2(mc2), .MaxCount3(mc3),
    .Collect(Collect), .Busy(Busy), .Grant(Grant), .Ack(Ack), .Err(Err),
    .ResData1(rd1), .ResData2(rd2), .ResData3(rd3),
    .ResCount1(rc1), .ResCount2(rc2), .ResCount3(rc3),
    .CaptureCount(cap_cnt), .TimeoutCount(to_cnt)
  );
  always #5 clk200 = ~clk200;
  always @(posedge clk200) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk200);
    #1;
  endtask
  task automatic model_reset;
    last_owner = 1;
    exp_cap = 0;
    exp_to = 0;
    exp_d = '0;
    exp_c = '0;
    last_collect = -1000;
  endtask
  task automatic chk_results(input string tag);
    chk({tag, "_resdata"}, 32'({rd1, rd2, rd3}), 32'(exp_d));
    chk({tag, "_rescount"}, 32'({rc1, rc2, rc3}), 32'(exp_c));
    chk({tag, "_capcnt"}, 32'(cap_cnt), 32'(exp_cap & 16'hFFFF));
    chk({tag, "_tocnt"}, 32'(to_cnt), 32'(exp_to));
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({Collect, Busy, Grant, Ack, Err}), 32'd0);
    chk({tag, "_res"}, 32'({rd1, rd2, rd3, rc1, rc2, rc3}), 32'd0);
    chk({tag, "_cnt"}, 32'({cap_cnt, to_cnt}), 32'd0);
  endtask
  // k < 0: never toggle (timeout); otherwise the done edge lands in WAIT cycle k (2..T-1)
  task automatic capture(input logic [1:0] rq, input int k, input bit drop, input bit stale, input bit rnd);
    int owner, c, ea;
    bit seen, bad;
    logic [1:0] exp_g;
    Req = rq;
    En = 1'b1;
    owner = (rq == 2'b11) ? 1 - last_owner : (rq == 2'b01 ? 0 : 1);
    exp_g = 2'(1 << owner);
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick;
      seen = (Collect === 1'b1);
    end
    chk("collect_seen", 32'(seen), 32'd1);
    if (!seen) return;
    c = cyc;
    chk("grant", 32'(Grant), 32'(exp_g));
    chk("busy_collect", 32'(Busy), 32'd1);
    chk("spacing_ok", 32'((c - last_collect) >= 3 + H), 32'd1);
    last_collect = c;
    last_owner = owner;
    if (drop) begin
      Req = 2'b00;
      En = 1'b0;
    end
    if (rnd) begin
      {md1, md2, md3} = 12'($urandom);
      {mc1, mc2, mc3} = 18'($urandom);
    end
    tick;
    chk("collect_single", 32'(Collect), 32'd0);
    if (k > 0) begin
      repeat (k - 2) tick;
      SortDoneTgl = ~SortDoneTgl;
    end
    ea = (k > 0) ? c + k + 2 : c + T + 1;
    seen = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < T + 8 && !seen; n++) begin
      if (Ack !== 2'b00) seen = 1'b1;
      else begin
        if (Collect !== 1'b0 || Err !== 1'b0) bad = 1'b1;
        tick;
      end
    end
    chk("wait_quiet", 32'(bad), 32'd0);
    chk("ack_seen", 32'(seen), 32'd1);
    chk("ack_time", 32'(cyc), 32'(ea));
    chk("ack", 32'(Ack), 32'(exp_g));
    chk("err", 32'(Err), 32'(k < 0));
    if (k > 0) begin
      exp_d = {md1, md2, md3};
      exp_c = {mc1, mc2, mc3};
      exp_cap++;
    end else if (exp_to < 255) exp_to++;
    chk_results("capture");
    bad = 1'b0;
    if (stale) begin
      tick;
      SortDoneTgl = ~SortDoneTgl;
      {md1, md2, md3} = 12'($urandom);
    end
    while (cyc < ea + H - 1) begin
      tick;
      if (Ack !== 2'b00 || Collect !== 1'b0 || Err !== 1'b0) bad = 1'b1;
    end
    chk("hold_quiet", 32'(bad), 32'd0);
    chk("busy_hold", 32'(Busy), 32'd1);
    tick;
    chk("idle_grant", 32'(Grant), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("stale_resdata", 32'({rd1, rd2, rd3}), 32'(exp_d));
  endtask
  initial begin
    bit bad;
    repeat (3) tick;
    chk_all_zero("reset");
    rstn = 1'b1;
    tick;
    md1 = 4'd5;
    mc1 = 6'd12;
    capture(2'b01, 3, 1'b0, 1'b0, 1'b0);
    chk("single_capcnt", 32'(cap_cnt), 32'd1);
    for (int i = 0; i < 4; i++) capture(2'b11, $urandom_range(2, T - 1), 1'b0, 1'b0, 1'b1);
    capture(2'b01, -1, 1'b0, 1'b0, 1'b1);
    capture(2'b10, 5, 1'b0, 1'b0, 1'b1);
    capture(2'b11, 4, 1'b0, 1'b1, 1'b1);
    capture(2'b01, T - 1, 1'b0, 1'b0, 1'b1);
    capture(2'b11, 6, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++)
      capture(2'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(2, T - 1)),
              1'($urandom), 1'($urandom), 1'b1);
    En = 1'b0;
    Req = 2'b11;
    bad = 1'b0;
    repeat (20) begin
      tick;
      if (Collect !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
    end
    chk("en_low_idle", 32'(bad), 32'd0);
    Req = 2'b10;
    En = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 8 && !bad; n++) begin
      tick;
      bad = (Collect === 1'b1);
    end
    chk("rst_collect_seen", 32'(bad), 32'd1);
    Req = 2'b00;
    repeat (3) tick;
    SortDoneTgl = 1'b1;
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset;
    tick;
    tick;
    rstn = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick;
      if (Ack !== 2'b00 || Busy !== 1'b0) bad = 1'b1;
    end
    chk("post_reset_quiet", 32'(bad), 32'd0);
    capture(2'b11, 7, 1'b0, 1'b0, 1'b1);
    Req = 2'b00;
    En = 1'b0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
